// File: rtl/apb_rr_master.sv
`default_nettype none
// ============================================================================
// apb_rr_master : round-robin APB2/APB3 master shared by NREQ requesters,
//                 with wait-state timeout abort
// Revision 1.0
// ============================================================================
module apb_rr_master #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_done,
    output logic [DW-1:0]        req_rdata,
    output logic                 req_err,
    output logic                 busy,
    output logic [AW-1:0]        PADDR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [DW-1:0]        PWDATA,
    input  logic [DW-1:0]        PRDATA,
    input  logic                 PREADY
);

    localparam int          c_PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_PW:0] c_NREQ = (c_PW+1)'(NREQ);
    localparam logic [8:0]  c_TMO  = 9'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_PW-1:0]   r_ptr;
    logic [c_PW-1:0]   r_grant;
    logic [7:0]        r_wait;

    logic [NREQ-1:0]   w_grant_oh;
    logic [NREQ-1:0]   w_cand;
    logic [2*NREQ-1:0] w_dbl;
    logic [c_PW-1:0]   w_off;
    logic [c_PW:0]     w_sum;
    logic [c_PW-1:0]   w_pick;
    logic              w_found;
    logic              w_timeout;
    logic              w_complete;
    logic              w_start;

    assign w_grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;

    // The requester whose completion is in flight (ACCESS) or just pulsed (IDLE)
    // still shows a stale valid and must not win again.
    assign w_cand = req_valid & ~((r_state == ACCESS) ? w_grant_oh : req_done);

    always_comb begin
        w_dbl   = {w_cand, w_cand} >> r_ptr;
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_found = 1'b1;
                w_off   = c_PW'(k);
            end
        end
        w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
        w_pick = (w_sum >= c_NREQ) ? c_PW'(w_sum - c_NREQ) : w_sum[c_PW-1:0];
    end

    assign w_timeout  = (TIMEOUT != 0) && !PREADY && (({1'b0, r_wait} + 9'd1) >= c_TMO);
    assign w_complete = (r_state == ACCESS) && (PREADY || w_timeout);
    assign w_start    = w_found && ((r_state == IDLE) || w_complete);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_wait    <= '0;
            req_done  <= '0;
            req_rdata <= '0;
            req_err   <= 1'b0;
            busy      <= 1'b0;
            PADDR     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            req_done <= '0;
            req_err  <= 1'b0;
            case (r_state)
                SETUP: begin
                    r_state <= ACCESS;
                    PENABLE <= 1'b1;
                    r_wait  <= '0;
                end
                ACCESS: begin
                    if (w_complete) begin
                        req_done  <= w_grant_oh;
                        req_err   <= !PREADY;
                        req_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
                        r_state   <= IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        busy      <= 1'b0;
                    end else if (r_wait != 8'hFF) begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // A new grant overrides the return to IDLE, giving back-to-back SETUP.
            if (w_start) begin
                r_state <= SETUP;
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                busy    <= 1'b1;
                r_grant <= w_pick;
                r_ptr   <= (w_pick == c_PW'(NREQ - 1)) ? '0 : w_pick + c_PW'(1);
                PADDR   <= req_addr[w_pick*AW +: AW];
                PWRITE  <= req_write[w_pick];
                PWDATA  <= req_wdata[w_pick*DW +: DW];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_master.sv
`default_nettype none
// ============================================================================
// tb_apb_rr_master : random requesters and APB slave against a reference model
// Revision 1.0
// ============================================================================
module tb_apb_rr_master;

    localparam int NREQ    = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic                 PCLK = 1'b0;
    logic                 PRESETn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_write = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      req_done;
    logic [DW-1:0]        req_rdata;
    logic                 req_err;
    logic                 busy;
    logic [AW-1:0]        PADDR;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [DW-1:0]        PWDATA;
    logic [DW-1:0]        PRDATA = '0;
    logic                 PREADY = 1'b0;

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
        .busy(busy), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    int     start_pct = 30;
    logic   hang = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int              idx;
        logic            err;
        logic [DW-1:0]   rdata;
        longint          due;
    } exp_t;
    exp_t sb[$];

    initial forever begin
        @(posedge PCLK);
        cyc++;
    end

    // Requesters and APB slave
    logic [NREQ-1:0] seen_done = '0;
    initial forever begin
        @(posedge PCLK);
        #1;
        PREADY = hang ? 1'b0 : ($urandom_range(0, 3) != 0);
        PRDATA = $urandom;
        for (int i = 0; i < NREQ; i++) begin
            if (seen_done[i]) begin
                seen_done[i] = 1'b0;
                req_valid[i] = 1'b0;
                if ($urandom_range(0, 99) < start_pct) begin
                    req_valid[i]           = 1'b1;
                    req_write[i]           = $urandom_range(0, 1) == 1;
                    req_addr[i*AW +: AW]   = $urandom;
                    req_wdata[i*DW +: DW]  = $urandom;
                end
            end else if (req_valid[i] && req_done[i]) begin
                seen_done[i] = 1'b1;
            end else if (!req_valid[i] && $urandom_range(0, 99) < start_pct) begin
                req_valid[i]           = 1'b1;
                req_write[i]           = $urandom_range(0, 1) == 1;
                req_addr[i*AW +: AW]   = $urandom;
                req_wdata[i*DW +: DW]  = $urandom;
            end
        end
    end

    function automatic int rr_pick(input logic [NREQ-1:0] pend, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    // Reference model: 0 = idle, 1 = setup, 2 = access
    initial begin
        int              mstate, mptr, mgrant, lowcnt, nxt, g;
        logic [NREQ-1:0] mdone, done_mask, pend;
        logic            arb, complete;
        logic [AW-1:0]   eaddr;
        logic            ewrite;
        logic [DW-1:0]   ewdata;
        exp_t            e;
        mstate = 0; mptr = 0; mgrant = 0; lowcnt = 0; mdone = '0;
        eaddr = '0; ewrite = 1'b0; ewdata = '0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                mstate = 0; mptr = 0; lowcnt = 0; mdone = '0;
            end else begin
                chk("psel", {63'd0, PSEL}, {63'd0, mstate != 0});
                chk("penable", {63'd0, PENABLE}, {63'd0, mstate == 2});
                chk("busy", {63'd0, busy}, {63'd0, mstate != 0});
                if (mstate != 0) begin
                    chk("paddr", {32'd0, PADDR}, {32'd0, eaddr});
                    chk("pwrite", {63'd0, PWRITE}, {63'd0, ewrite});
                    chk("pwdata", {32'd0, PWDATA}, {32'd0, ewdata});
                end
                nxt = mstate; arb = 1'b0; complete = 1'b0;
                pend = '0; done_mask = '0;
                case (mstate)
                    0: begin
                        pend = req_valid & ~mdone;
                        arb  = 1'b1;
                    end
                    1: begin
                        nxt = 2;
                        lowcnt = 0;
                    end
                    default: begin
                        e.idx = mgrant;
                        e.due = cyc + 1;
                        if (PREADY) begin
                            complete = 1'b1;
                            e.err    = 1'b0;
                            e.rdata  = ewrite ? '0 : PRDATA;
                        end else begin
                            lowcnt++;
                            if (TIMEOUT > 0 && lowcnt == TIMEOUT) begin
                                complete = 1'b1;
                                e.err    = 1'b1;
                                e.rdata  = '0;
                            end
                        end
                        if (complete) begin
                            sb.push_back(e);
                            done_mask = '0;
                            done_mask[mgrant] = 1'b1;
                            pend = req_valid & ~done_mask;
                            arb  = 1'b1;
                            nxt  = 0;
                        end
                    end
                endcase
                if (arb && pend != '0) begin
                    g      = rr_pick(pend, mptr);
                    mgrant = g;
                    mptr   = (g + 1) % NREQ;
                    eaddr  = req_addr[g*AW +: AW];
                    ewrite = req_write[g];
                    ewdata = req_wdata[g*DW +: DW];
                    nxt    = 1;
                end
                mdone  = done_mask;
                mstate = nxt;
            end
        end
    end

    // Completion monitor
    initial forever begin
        logic [NREQ-1:0] oh;
        exp_t            e;
        @(negedge PCLK);
        if (!PRESETn) begin
            sb.delete();
        end else if (req_done != '0) begin
            if (sb.size() == 0 || sb[0].due != cyc) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got req_done=%b expected none (cycle %0d)", req_done, cyc);
            end else begin
                e  = sb.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                chk("req_done", {60'd0, req_done}, {60'd0, oh});
                chk("req_err", {63'd0, req_err}, {63'd0, e.err});
                chk("req_rdata", {32'd0, req_rdata}, {32'd0, e.rdata});
            end
        end else begin
            chk("req_err_idle", {63'd0, req_err}, 64'd0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL done_missing: got req_done=0 expected requester %0d (cycle %0d)", e.idx, cyc);
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_psel", {63'd0, PSEL}, 64'd0);
        chk("rst_penable", {63'd0, PENABLE}, 64'd0);
        chk("rst_paddr", {32'd0, PADDR}, 64'd0);
        chk("rst_pwrite", {63'd0, PWRITE}, 64'd0);
        chk("rst_pwdata", {32'd0, PWDATA}, 64'd0);
        chk("rst_req_done", {60'd0, req_done}, 64'd0);
        chk("rst_req_rdata", {32'd0, req_rdata}, 64'd0);
        chk("rst_req_err", {63'd0, req_err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic found;
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check_reset_outputs();
        PRESETn = 1'b1;

        start_pct = 30;
        repeat (400) @(posedge PCLK);
        start_pct = 100;
        repeat (300) @(posedge PCLK);
        start_pct = 60;
        for (int h = 0; h < 12; h++) begin
            hang = 1'b1;
            repeat ($urandom_range(10, 24)) @(posedge PCLK);
            hang = 1'b0;
            repeat ($urandom_range(5, 20)) @(posedge PCLK);
        end

        start_pct = 100;
        found = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(posedge PCLK);
            #1;
            if (PSEL && PENABLE) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL reach_access: got no ACCESS within 200 cycles expected ACCESS");
        end else begin
            #1;
            PRESETn = 1'b0;
            #1;
            chk("midrst_psel", {63'd0, PSEL}, 64'd0);
            chk("midrst_penable", {63'd0, PENABLE}, 64'd0);
            chk("midrst_req_done", {60'd0, req_done}, 64'd0);
            chk("midrst_busy", {63'd0, busy}, 64'd0);
            @(posedge PCLK);
            #1;
            PRESETn = 1'b1;
        end

        start_pct = 50;
        repeat (400) @(posedge PCLK);
        @(negedge PCLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_rr_master.md
# apb_rr_master

APB master sequencer that shares one APB2/APB3 peripheral bus between NREQ local requesters. It arbitrates round-robin, drives the two-phase SETUP/ACCESS protocol toward the selected slave (for example the counter slave), and returns read data and completion to the winning requester. It also terminates hung transfers with an error after a programmable number of wait cycles.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8)
- AW, 32: address width
- DW, 32: data width
- TIMEOUT, 16: maximum consecutive ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
- PCLK  in  1  bus clock, all logic on rising edge
- PRESETn  in  1  reset, asynchronous assert, active-low
- req_valid  in  NREQ  per-requester request, held with payload stable until its req_done
- req_write  in  NREQ  per-requester direction, 1 = write
- req_addr  in  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data, same packing
- req_done  out  NREQ  one-hot, one-cycle completion pulse
- req_rdata  out  DW  read data of the completed transfer, valid while req_done is high
- req_err  out  1  high with req_done when the transfer timed out
- busy  out  1  high in SETUP and ACCESS
- PADDR  out  AW  APB address
- PSEL  out  1  APB select (single slave)
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DW  APB write data
- PRDATA  in  DW  APB read data
- PREADY  in  1  APB ready; tie to 1 for APB2 slaves

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid bit is set, grant the requester selected by round-robin, latch its addr/write/wdata into the APB output registers, and go to SETUP. Otherwise stay in IDLE with PSEL=0.
- SETUP: PSEL=1, PENABLE=0. Unconditionally go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, address, control and data held.
  - PREADY=1: capture PRDATA (0 for writes) and pulse req_done[grant] with req_err=0.
  - TIMEOUT>0 and PREADY has been low for TIMEOUT consecutive ACCESS cycles: pulse req_done[grant] with req_err=1 and req_rdata=0.
  - On either completion, re-arbitrate among req_valid with the just-completed requester masked out. If any other request is valid, go directly to SETUP (back-to-back). Otherwise go to IDLE.
- Round-robin: the priority pointer moves to the requester after the last granted one. Search order is ptr, ptr+1, … modulo NREQ. A requester waits at most NREQ-1 transfers.
- The wait counter is 8 bits wide. It clears on entering ACCESS and saturates; it is not used when TIMEOUT=0.
- Wait PREADY is sampled only in ACCESS and ignored elsewhere.
- The APB output registers change only on entry to SETUP; in IDLE they keep the last values, while PSEL and PENABLE are 0.
- A requester dropping req_valid mid-transfer does not abort the transfer; completion is still pulsed.

## Timing
- Reset (asynchronous): state=IDLE, pointer=0, and all outputs are 0 (PSEL, PENABLE, PADDR, PWRITE, PWDATA, req_done, req_rdata, req_err, busy). A reset asserted mid-transfer ends it immediately with no req_done.
- Idle-to-bus latency: req_valid high in cycle 0 gives SETUP in cycle 1 and ACCESS in cycle 2. With PREADY=1, req_done is high in cycle 3. Minimum transfer is 2 bus cycles.
- Back-to-back: the next SETUP coincides with the req_done cycle, so sustained throughput is 1 transfer per 2 cycles with no IDLE gap.
- Each wait cycle (PREADY=0) extends ACCESS by 1 cycle.
- Timeout: the abort req_done appears the cycle after the TIMEOUT-th low-PREADY ACCESS cycle.
- A requester must deassert or change its request in the cycle after req_done. The masking rule covers its stale valid in the done cycle only.

## Test plan
- Single write: req_valid[0]=1, addr 0x10, wdata 0xA5A5 → SETUP in cycle 1, ACCESS in cycle 2 with PWRITE=1 and PWDATA=0xA5A5, req_done=4'b0001 in cycle 3, req_err=0.
- Single read from the counter slave after 5 enabled cycles: req_valid[2]=1, write=0 → req_rdata equals the slave's PRDATA sampled in ACCESS, req_done=4'b0100.
- Fairness: all four requesters held valid continuously → grant order 0,1,2,3,0,… with one transfer every 2 cycles and busy held high.
- Wait states: PREADY low for 3 ACCESS cycles → ACCESS lasts 4 cycles, req_done arrives in cycle 6, req_err=0.
- Timeout: TIMEOUT=16, PREADY stuck at 0 → req_done with req_err=1 and req_rdata=0 after 16 ACCESS cycles, then the next pending requester is granted.
- Reset mid-ACCESS: PRESETn low during ACCESS → PSEL and PENABLE drop immediately, no req_done. After release, a held request restarts from SETUP with pointer=0.
